// File: rtl/mxu_feed_loader.sv
// ---------------------------------------------------------------------------
// mxu_feed_loader
//
// Write-side loader for the accelerator's north and west feed buffers.
// A valid/ready word stream from the host is scattered into the per-lane
// feed buffers with the systolic skew already applied: lane i of each side
// gets i leading zero entries, then len data words, then GRID_SIZE-1-i
// trailing zero entries, so every lane holds exactly depth = len+GRID_SIZE-1
// entries.
//
// Lanes are filled strictly in order: north lane 0..GRID_SIZE-1, then west
// lane 0..GRID_SIZE-1. Each lane is written at addresses 0..depth-1 in order,
// one write per cycle, with stalls only while waiting on stream words.
// After the final write, depth is published and done pulses so that the
// accelerator can enable its read side.
//
// Ports:
//   clk       clock, all state changes on the rising edge
//   rst       asynchronous, active-high reset
//   start     one-cycle load request, only looked at while idle
//   load_len  data words per lane, captured together with start
//   in_valid  stream word valid
//   in_ready  stream word accepted when in_valid && in_ready (registered)
//   in_data   stream word
//   wr_en     buffer write strobe
//   wr_sel    buffer side: 0 = north, 1 = west
//   wr_lane   target lane within the selected side
//   wr_addr   target entry within the lane buffer
//   wr_data   value written (zero for skew/tail fill)
//   busy      a load is in progress
//   done      one-cycle pulse when the load has completed
//   error     one-cycle pulse when a start request was rejected
//   depth     valid entries per lane of the last accepted load
// ---------------------------------------------------------------------------
module mxu_feed_loader #(
    parameter int NUM_SIZE    = 16,
    parameter int GRID_SIZE   = 2,
    parameter int BUFFER_LEN  = 32,
    parameter int ADDRESS_LEN = 5,
    parameter int LANE_W      = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [ADDRESS_LEN:0]   load_len,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [NUM_SIZE-1:0]    in_data,
    output logic                   wr_en,
    output logic                   wr_sel,
    output logic [LANE_W-1:0]      wr_lane,
    output logic [ADDRESS_LEN-1:0] wr_addr,
    output logic [NUM_SIZE-1:0]    wr_data,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic [ADDRESS_LEN:0]   depth
);

    // Elaboration-time sanity checks on the derived widths.
    if (ADDRESS_LEN != $clog2(BUFFER_LEN)) begin : g_badAddressLen
        $error("mxu_feed_loader: ADDRESS_LEN must equal clog2(BUFFER_LEN)");
    end
    if (LANE_W != ((GRID_SIZE > 1) ? $clog2(GRID_SIZE) : 1)) begin : g_badLaneW
        $error("mxu_feed_loader: LANE_W must equal max(1, clog2(GRID_SIZE))");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_SKEW,
        S_DATA,
        S_TAIL,
        S_FINISH
    } state_t;

    // Internal counters are one bit wider than depth so that len+GRID_SIZE-1
    // can never overflow while the request is being validated.
    localparam int                CW         = ADDRESS_LEN + 2;
    localparam logic [CW-1:0]     SKEW_EXTRA = CW'(GRID_SIZE - 1);
    localparam logic [CW-1:0]     BUF_LIMIT  = CW'(BUFFER_LEN);
    localparam logic [LANE_W-1:0] LAST_LANE  = LANE_W'(GRID_SIZE - 1);

    state_t                 state_q, state_d;
    logic                   side_q, side_d;
    logic [LANE_W-1:0]      lane_q, lane_d;
    logic [CW-1:0]          addr_q, addr_d;
    logic [CW-1:0]          len_q, len_d;
    logic [ADDRESS_LEN:0]   depth_q, depth_d;

    logic                   wrEn_q, wrEn_d;
    logic                   wrSel_q, wrSel_d;
    logic [LANE_W-1:0]      wrLane_q, wrLane_d;
    logic [ADDRESS_LEN-1:0] wrAddr_q, wrAddr_d;
    logic [NUM_SIZE-1:0]    wrData_q, wrData_d;
    logic                   inReady_q, inReady_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   error_q, error_d;

    logic [CW-1:0]          reqDepth;
    logic [CW-1:0]          nextAddr;
    logic [LANE_W-1:0]      laneNext;
    logic                   doWrite;

    // Which phase of a lane a given address falls into. Addresses below the
    // lane index are skew zeros, the next len addresses carry stream data and
    // anything after that is tail fill. Deriving the state from the address
    // lets a lane start directly in DATA (lane 0) or finish without a TAIL
    // (last lane) with no idle cycle in between.
    function automatic state_t lanePhase(
        input logic [LANE_W-1:0] lane,
        input logic [CW-1:0]     addr,
        input logic [CW-1:0]     len
    );
        logic [CW-1:0] laneExt;
        laneExt = CW'(lane);
        if (addr < laneExt) begin
            return S_SKEW;
        end else if (addr < laneExt + len) begin
            return S_DATA;
        end else begin
            return S_TAIL;
        end
    endfunction

    // Next-state and output decode. Every output is computed here one cycle
    // ahead and registered below, so a write decided in this cycle shows up
    // on wr_* in the next one. in_ready is likewise the registered image of
    // "the next state is DATA", which makes it high exactly while a data
    // address of the current lane is still outstanding.
    always_comb begin
        state_d   = state_q;
        side_d    = side_q;
        lane_d    = lane_q;
        addr_d    = addr_q;
        len_d     = len_q;
        depth_d   = depth_q;
        wrEn_d    = 1'b0;
        wrSel_d   = wrSel_q;
        wrLane_d  = wrLane_q;
        wrAddr_d  = wrAddr_q;
        wrData_d  = wrData_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        error_d   = 1'b0;
        inReady_d = 1'b0;
        reqDepth  = CW'(load_len) + SKEW_EXTRA;
        nextAddr  = addr_q + CW'(1);
        laneNext  = lane_q + LANE_W'(1);
        doWrite   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if ((load_len != '0) && (reqDepth <= BUF_LIMIT)) begin
                        len_d   = CW'(load_len);
                        depth_d = reqDepth[ADDRESS_LEN:0];
                        busy_d  = 1'b1;
                        side_d  = 1'b0;
                        lane_d  = '0;
                        addr_d  = '0;
                        state_d = lanePhase(LANE_W'(0), CW'(0), CW'(load_len));
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end

            S_SKEW, S_DATA, S_TAIL: begin
                if (state_q == S_DATA) begin
                    doWrite = in_valid && inReady_q;
                end else begin
                    doWrite = 1'b1;
                end

                if (doWrite) begin
                    wrEn_d   = 1'b1;
                    wrSel_d  = side_q;
                    wrLane_d = lane_q;
                    wrAddr_d = addr_q[ADDRESS_LEN-1:0];
                    wrData_d = (state_q == S_DATA) ? in_data : '0;

                    if (nextAddr == CW'(depth_q)) begin
                        addr_d = '0;
                        if (lane_q == LAST_LANE) begin
                            lane_d = '0;
                            if (side_q) begin
                                state_d = S_FINISH;
                            end else begin
                                side_d  = 1'b1;
                                state_d = lanePhase(LANE_W'(0), CW'(0), len_q);
                            end
                        end else begin
                            lane_d  = laneNext;
                            state_d = lanePhase(laneNext, CW'(0), len_q);
                        end
                    end else begin
                        addr_d  = nextAddr;
                        state_d = lanePhase(lane_q, nextAddr, len_q);
                    end
                end
            end

            S_FINISH: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        inReady_d = (state_d == S_DATA);
    end

    // State and output registers. Reset drops everything to zero at once,
    // which also abandons any load in progress; buffer contents are not
    // touched because no further write strobe is issued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            side_q    <= 1'b0;
            lane_q    <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            depth_q   <= '0;
            wrEn_q    <= 1'b0;
            wrSel_q   <= 1'b0;
            wrLane_q  <= '0;
            wrAddr_q  <= '0;
            wrData_q  <= '0;
            inReady_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            side_q    <= side_d;
            lane_q    <= lane_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            depth_q   <= depth_d;
            wrEn_q    <= wrEn_d;
            wrSel_q   <= wrSel_d;
            wrLane_q  <= wrLane_d;
            wrAddr_q  <= wrAddr_d;
            wrData_q  <= wrData_d;
            inReady_q <= inReady_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            error_q   <= error_d;
        end
    end

    assign in_ready = inReady_q;
    assign wr_en    = wrEn_q;
    assign wr_sel   = wrSel_q;
    assign wr_lane  = wrLane_q;
    assign wr_addr  = wrAddr_q;
    assign wr_data  = wrData_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign error    = error_q;
    assign depth    = depth_q;

endmodule

// File: tb/tb_mxu_feed_loader.sv
// ---------------------------------------------------------------------------
// tb_mxu_feed_loader
//
// Scoreboard bench for mxu_feed_loader. Each load builds the complete list
// of buffer writes it should produce straight from the skew rule (lane i:
// i zeros, len words, GRID_SIZE-1-i zeros, north lanes then west lanes) and
// queues it. A free-running monitor pops one entry per observed write strobe
// and checks done/depth whenever done pulses.
// ---------------------------------------------------------------------------
module tb_mxu_feed_loader;

    localparam int NUM_SIZE    = 16;
    localparam int GRID_SIZE   = 2;
    localparam int BUFFER_LEN  = 32;
    localparam int ADDRESS_LEN = 5;
    localparam int LANE_W      = 1;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   start;
    logic [ADDRESS_LEN:0]   load_len;
    logic                   in_valid;
    logic                   in_ready;
    logic [NUM_SIZE-1:0]    in_data;
    logic                   wr_en;
    logic                   wr_sel;
    logic [LANE_W-1:0]      wr_lane;
    logic [ADDRESS_LEN-1:0] wr_addr;
    logic [NUM_SIZE-1:0]    wr_data;
    logic                   busy;
    logic                   done;
    logic                   error;
    logic [ADDRESS_LEN:0]   depth;

    typedef struct {
        logic                   sel;
        logic [LANE_W-1:0]      lane;
        logic [ADDRESS_LEN-1:0] addr;
        logic [NUM_SIZE-1:0]    data;
        bit                     isData;
    } wr_t;

    wr_t expWr[$];
    int  expDepth[$];

    int  nChecks;
    int  nFails;
    int  curDepth;
    int  cycle       = 0;
    int  wrCount     = 0;
    int  doneCount   = 0;
    int  lastWrCycle = -100;
    int  doneCycle   = 0;
    wr_t monE;
    bit  readyOk;

    mxu_feed_loader #(
        .NUM_SIZE   (NUM_SIZE),
        .GRID_SIZE  (GRID_SIZE),
        .BUFFER_LEN (BUFFER_LEN),
        .ADDRESS_LEN(ADDRESS_LEN),
        .LANE_W     (LANE_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .load_len(load_len),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data (in_data),
        .wr_en   (wr_en),
        .wr_sel  (wr_sel),
        .wr_lane (wr_lane),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .busy    (busy),
        .done    (done),
        .error   (error),
        .depth   (depth)
    );

    always #5 clk = ~clk;

    // One comparison with a pass/fail tally.
    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // A comparison that has already been decided as failed.
    task automatic failNow(input string name, input string detail);
        nChecks++;
        nFails++;
        $display("[TB] FAIL %s: %s (t=%0t)", name, detail, $time);
    endtask

    // Monitor: samples on the falling edge, pops one expected write per strobe
    // and checks the completion handshake whenever done pulses.
    always @(negedge clk) begin
        cycle++;
        if (rst !== 1'b1) begin
            if (wr_en === 1'b1) begin
                wrCount++;
                lastWrCycle = cycle;
                if (expWr.size() == 0) begin
                    failNow("unexpected_write",
                            $sformatf("sel=%0d lane=%0d addr=%0d data=0x%0h, none expected",
                                      wr_sel, wr_lane, wr_addr, wr_data));
                end else begin
                    monE = expWr.pop_front();
                    checkOutput("write_sel_lane_addr_data",
                                {wr_sel, wr_lane, wr_addr, wr_data},
                                {monE.sel, monE.lane, monE.addr, monE.data});
                end
            end
            if (in_ready === 1'b1) begin
                readyOk = (expWr.size() > 0) ? expWr[0].isData : 1'b0;
                checkOutput("ready_only_for_data_slot", {busy, readyOk}, 2'b11);
            end
            if (done === 1'b1) begin
                doneCount++;
                doneCycle = cycle;
                checkOutput("done_one_cycle_after_last_write", cycle - lastWrCycle, 1);
                checkOutput("writes_outstanding_at_done", expWr.size(), 0);
                checkOutput("busy_low_at_done", busy, 0);
                if (expDepth.size() == 0) begin
                    failNow("unexpected_done", "done pulsed with no load pending");
                end else begin
                    checkOutput("depth_at_done", depth, expDepth.pop_front());
                end
            end
        end
    end

    // Asynchronous reset: outputs must clear immediately and stay quiet.
    task automatic doReset();
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        #1;
        checkOutput("reset_outputs_zero",
                    {wr_en, wr_sel, wr_lane, wr_addr, wr_data, in_ready, busy, done, error, depth}, 0);
        expWr.delete();
        expDepth.delete();
        curDepth = 0;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("reset_held_quiet", {wr_en, busy, in_ready, done, error}, 0);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            #1;
            checkOutput("post_reset_idle", {wr_en, busy, in_ready, done, error}, 0);
        end
    endtask

    // Rejected start request: single error pulse, nothing else moves.
    task automatic applyIllegal(input int len);
        @(negedge clk);
        #1;
        start    = 1'b1;
        load_len = len[ADDRESS_LEN:0];
        @(negedge clk);
        #1;
        start = 1'b0;
        checkOutput("illegal_error_pulse", error, 1);
        checkOutput("illegal_no_activity", {wr_en, busy, in_ready}, 0);
        checkOutput("illegal_depth_kept", depth, curDepth);
        @(negedge clk);
        #1;
        checkOutput("illegal_error_single_cycle", error, 0);
        checkOutput("illegal_still_idle", {wr_en, busy}, 0);
    endtask

    // One load. vmode: 0 = in_valid held high, 1 = toggling, 2 = random.
    // midStart re-pulses start during the load; resetAfter > 0 resets the
    // design once that many writes of this load have been seen.
    task automatic applyStimulus(input int len, input int vmode, input bit midStart, input int resetAfter);
        logic [NUM_SIZE-1:0] stream[$];
        wr_t w;
        int  depthV;
        int  k;
        int  idx;
        int  startDone;
        int  startWr;
        int  startCycle;
        int  budget;
        bit  pend;
        bit  v;

        depthV = len + GRID_SIZE - 1;
        stream.delete();
        for (int n = 0; n < 2 * GRID_SIZE * len; n++) begin
            stream.push_back(NUM_SIZE'($urandom_range(1, 65535)));
        end
        k = 0;
        for (int s = 0; s < 2; s++) begin
            for (int l = 0; l < GRID_SIZE; l++) begin
                for (int a = 0; a < depthV; a++) begin
                    w.sel  = s[0];
                    w.lane = l[LANE_W-1:0];
                    w.addr = a[ADDRESS_LEN-1:0];
                    if (a >= l && a < l + len) begin
                        w.data   = stream[k];
                        w.isData = 1'b1;
                        k++;
                    end else begin
                        w.data   = '0;
                        w.isData = 1'b0;
                    end
                    expWr.push_back(w);
                end
            end
        end
        expDepth.push_back(depthV);

        startDone = doneCount;
        startWr   = wrCount;
        @(negedge clk);
        #1;
        start      = 1'b1;
        load_len   = len[ADDRESS_LEN:0];
        in_valid   = 1'b0;
        startCycle = cycle;
        curDepth   = depthV;
        idx        = 0;
        pend       = 1'b0;
        budget     = 0;

        while (doneCount == startDone) begin
            @(negedge clk);
            #1;
            start = 1'b0;
            if (budget >= 4000) begin
                failNow("done_timeout", $sformatf("no done after %0d cycles, len=%0d", budget, len));
                expWr.delete();
                expDepth.delete();
                break;
            end
            if (resetAfter > 0 && (wrCount - startWr) >= resetAfter) begin
                doReset();
                return;
            end
            if (pend) idx++;
            case (vmode)
                0:       v = 1'b1;
                1:       v = (budget % 2 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            if (idx >= stream.size()) v = 1'b0;
            in_valid = v;
            in_data  = v ? stream[idx] : NUM_SIZE'($urandom);
            pend     = v && (in_ready === 1'b1);
            if (midStart && budget == 5) begin
                start    = 1'b1;
                load_len = 6'd1;
            end
            if (error !== 1'b0) begin
                failNow("spurious_error", "error pulsed during a legal load");
            end
            budget++;
        end
        in_valid = 1'b0;

        if (doneCount != startDone) begin
            checkOutput("words_consumed", idx, stream.size());
            if (vmode == 0) begin
                checkOutput("load_time", doneCycle - startCycle, 2 * GRID_SIZE * depthV + 2);
            end
        end
    endtask

    initial begin
        nChecks  = 0;
        nFails   = 0;
        curDepth = 0;
        rst      = 1'b0;
        start    = 1'b0;
        load_len = '0;
        in_valid = 1'b0;
        in_data  = '0;

        doReset();

        applyStimulus(3, 0, 1'b0, 0);
        applyStimulus(3, 1, 1'b0, 0);

        applyIllegal(0);
        applyIllegal(32);
        applyStimulus(31, 2, 1'b0, 0);
        applyIllegal(32);

        applyStimulus(3, 0, 1'b1, 0);

        applyStimulus(3, 0, 1'b0, 5);
        applyStimulus(1, 0, 1'b0, 0);

        repeat (4) begin
            applyStimulus($urandom_range(1, 31), $urandom_range(0, 2), 1'b0, 0);
        end

        repeat (3) @(negedge clk);
        #1;
        checkOutput("scoreboard_drained", expWr.size(), 0);
        checkOutput("no_pending_done", expDepth.size(), 0);
        checkOutput("final_idle", {busy, wr_en, in_ready}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/mxu_feed_loader.md
Name: mxu_feed_loader

Overview:
- Write-side counterpart of the accelerator's north/west feed buffers.
- Accepts a valid/ready word stream from the host and writes it into the per-lane feed buffers, inserting the systolic skew zeros: lane i is delayed by i cycles.
- When finished, publishes the per-lane feed depth and pulses done so the accelerator can assert ce and begin reading.

Parameters:
- NUM_SIZE, 16, data word width.
- GRID_SIZE, 2, number of lanes per side (north and west).
- BUFFER_LEN, 32, entries per lane buffer.
- ADDRESS_LEN, 5, buffer address width; must equal clog2(BUFFER_LEN).
- LANE_W, 1, lane index width; must equal max(1, clog2(GRID_SIZE)).

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle load request; sampled only in IDLE.
- load_len  in  ADDRESS_LEN+1  data words per lane; sampled with start.
- in_valid  in  1  stream word valid.
- in_ready  out  1  stream word accepted when in_valid&&in_ready.
- in_data  in  NUM_SIZE  stream word.
- wr_en  out  1  buffer write strobe.
- wr_sel  out  1  0 = north buffer, 1 = west buffer.
- wr_lane  out  LANE_W  target lane.
- wr_addr  out  ADDRESS_LEN  target entry.
- wr_data  out  NUM_SIZE  write data.
- busy  out  1  load in progress.
- done  out  1  one-cycle pulse, load complete.
- error  out  1  one-cycle pulse, start rejected.
- depth  out  ADDRESS_LEN+1  entries valid per lane (load_len+GRID_SIZE-1).

Behaviour:
- Reset: all outputs 0; state IDLE; lane/side/address counters 0.
- Reset mid-load aborts immediately. No further writes are issued. Buffer contents already written are not touched.
- All outputs are registered.
- IDLE:
  - in_ready=0, busy=0.
  - start with 1 <= load_len and load_len+GRID_SIZE-1 <= BUFFER_LEN: latch len; depth <= len+GRID_SIZE-1; busy <= 1; side=north, lane=0, addr=0; go to SKEW.
  - Illegal start (load_len=0 or depth overflow): error pulses the next cycle, no writes, state stays IDLE, depth unchanged.
- Per lane, exactly depth writes in address order 0..depth-1:
  - SKEW: lane index i zero-writes at addr 0..i-1, one per cycle, no stream consumption. Skipped when i=0.
  - DATA: in_ready=1; each accepted word writes addr i..i+len-1 in order. in_valid low stalls with no write and no address advance.
  - TAIL: GRID_SIZE-1-i zero-writes fill the remaining addresses. Skipped when i=GRID_SIZE-1.
  - NEXT: advance lane; after the last north lane go to west lane 0; after the last west lane go to FINISH. Zero-cycle transition, so no bubble between lanes.
- Order of consumption: north lane 0..GRID_SIZE-1, then west lane 0..GRID_SIZE-1; len words each.
- Write timing: a write decided in cycle N (handshake or zero-fill) appears on wr_* during cycle N+1 with wr_en=1. wr_en=0 otherwise. wr_sel/wr_lane/wr_addr/wr_data don't-care when wr_en=0.
- in_ready is registered: it is 1 exactly in cycles where the state is DATA and the next data address is still within the lane. It drops in the cycle after the last word of a lane is accepted, and never accepts a word beyond len per lane.
- FINISH: done=1 and busy=0 in the cycle after the final wr_en cycle; return to IDLE.
- Minimum load time with in_valid held high: 2*GRID_SIZE*depth write cycles + 2.
- start while busy is ignored; no error is raised.
- Address arithmetic: addr never exceeds depth-1 <= BUFFER_LEN-1; no wrap occurs.

Test Plan:
- GRID=2, len=3, stream d0..d11 with in_valid always high. Required writes, 16 total, then one done pulse; depth=4:
  - N0: a0..2 = d0,d1,d2; a3 = 0.
  - N1: a0 = 0; a1..3 = d3,d4,d5.
  - W0: a0..2 = d6,d7,d8; a3 = 0.
  - W1: a0 = 0; a1..3 = d9,d10,d11.
- Same load with in_valid toggling 1-0-1-0 -> identical write sequence, gaps only during DATA, no duplicate or lost words; in_ready never high in SKEW/TAIL.
- start with load_len=0, then load_len=32 (depth 33 > 32) -> error pulses each time, wr_en stays 0, busy 0, depth unchanged; load_len=31 accepted, depth=32, last write addr 31.
- start pulsed again mid-load -> ignored; sequence and done identical to the uninterrupted run.
- Assert rst after 5 writes -> all outputs 0 at once, no further wr_en; a new start with len=1 completes with depth=2, 8 writes.
- len=1 -> N0 a0=d0, a1=0; N1 a0=0, a1=d1; W lanes likewise with d2,d3; done follows the last write by one cycle.
